// File: rtl/cpu_garage_pkg.sv
// Shared types for the data-memory port-B arbiter: read-return tags, grant codes and
// the default framebuffer placement.
package cpu_garage_pkg;

    localparam int unsigned DEFAULT_SCREEN_BASE  = 32'h4000;
    localparam int unsigned DEFAULT_SCREEN_WORDS = 8192;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_VGA,
        TAG_DBG
    } t_rd_tag;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_CPU,
        GNT_VGA,
        GNT_DBG
    } t_grant;

endpackage

// File: rtl/dmem_prefetch_fifo.sv
// Small synchronous FIFO feeding VGA scanout: flush input, registered head word,
// occupancy count and a same-cycle underrun flag for pops on an empty FIFO.
module dmem_prefetch_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] pushData,
    input  logic              pop,
    output logic [DATA_W-1:0] headData,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              underrun
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rdPtr, wrPtr, rdPtrNext;
    logic [CNT_W-1:0]  countNext;
    logic [DATA_W-1:0] headNext;
    logic              doPop, doPush;

    assign empty    = (count == '0);
    assign underrun = pop && empty;
    assign doPop    = pop && !empty;
    assign doPush   = push && ((count != CNT_W'(DEPTH)) || doPop);

    always_comb begin
        countNext = count;
        if (doPush && !doPop) begin
            countNext = count + 1'b1;
        end else if (!doPush && doPop) begin
            countNext = count - 1'b1;
        end
        rdPtrNext = doPop ? rdPtr + 1'b1 : rdPtr;
        // Head comes from the incoming word when nothing older survives this cycle.
        if (countNext == '0) begin
            headNext = '0;
        end else if (count == CNT_W'(doPop)) begin
            headNext = pushData;
        end else begin
            headNext = mem[rdPtrNext];
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
            headData <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            rdPtr    <= rdPtrNext;
            count    <= countNext;
            headData <= headNext;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Port-B arbiter: CPU stores always win; spare cycles go round-robin to VGA prefetch and,
// when DMEM_ARB_DEBUG_EN is defined, to the host debug port.
module dmem_port_arbiter
    import cpu_garage_pkg::*;
#(
    parameter int unsigned        ADDR_W       = 15,
    parameter int unsigned        DATA_W       = 16,
    parameter int unsigned        FIFO_DEPTH   = 4,
    parameter logic [ADDR_W-1:0]  SCREEN_BASE  = ADDR_W'(DEFAULT_SCREEN_BASE),
    parameter int unsigned        SCREEN_WORDS = DEFAULT_SCREEN_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_wr_en,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    input  logic              vga_frame_start,
    input  logic              vga_pop,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_empty,
    output logic              vga_underrun,
    input  logic              dbg_req_valid,
    output logic              dbg_req_ready,
    input  logic              dbg_req_we,
    input  logic [ADDR_W-1:0] dbg_req_addr,
    input  logic [DATA_W-1:0] dbg_req_wdata,
    output logic              dbg_rsp_valid,
    output logic [DATA_W-1:0] dbg_rsp_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned       CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(32'(SCREEN_BASE) + SCREEN_WORDS - 1);

    logic [ADDR_W-1:0] fetchPtr;
    logic              prefetchActive;
    t_rd_tag           rdTag, rdTagNext;
    t_grant            grant;
    logic [CNT_W-1:0]  fifoCount;
    logic              vgaInflight, vgaElig, dbgElig;

    assign vgaInflight = (rdTag == TAG_VGA);
    // The tagged read plus any read granted now must still fit in the FIFO.
    assign vgaElig = prefetchActive && !vga_frame_start &&
                     (({1'b0, fifoCount} + (CNT_W + 1)'(vgaInflight)) < (CNT_W + 1)'(FIFO_DEPTH));

`ifdef DMEM_ARB_DEBUG_EN
    logic lastGntDbg;

    assign dbgElig = dbg_req_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            lastGntDbg    <= 1'b0;
            dbg_rsp_valid <= 1'b0;
            dbg_rsp_data  <= '0;
        end else begin
            if (grant == GNT_VGA) begin
                lastGntDbg <= 1'b0;
            end else if (grant == GNT_DBG) begin
                lastGntDbg <= 1'b1;
            end
            dbg_rsp_valid <= (rdTag == TAG_DBG);
            if (rdTag == TAG_DBG) begin
                dbg_rsp_data <= ram_rdata;
            end
        end
    end
`else
    logic unusedDbg;

    assign dbgElig       = 1'b0;
    assign unusedDbg     = ^{dbg_req_valid, dbg_req_we, dbg_req_addr, dbg_req_wdata};
    assign dbg_rsp_valid = 1'b0;
    assign dbg_rsp_data  = '0;
`endif

    always_comb begin
        grant = GNT_NONE;
        if (cpu_wr_en) begin
            grant = GNT_CPU;
`ifdef DMEM_ARB_DEBUG_EN
        end else if (vgaElig && dbgElig) begin
            grant = lastGntDbg ? GNT_VGA : GNT_DBG;
`endif
        end else if (vgaElig) begin
            grant = GNT_VGA;
        end else if (dbgElig) begin
            grant = GNT_DBG;
        end
    end

    always_comb begin
        ram_we        = 1'b0;
        ram_addr      = '0;
        ram_wdata     = '0;
        dbg_req_ready = 1'b0;
        rdTagNext     = TAG_NONE;
        unique case (grant)
            GNT_CPU: begin
                ram_we    = 1'b1;
                ram_addr  = cpu_wr_addr;
                ram_wdata = cpu_wr_data;
            end
            GNT_VGA: begin
                ram_addr  = fetchPtr;
                rdTagNext = TAG_VGA;
            end
`ifdef DMEM_ARB_DEBUG_EN
            GNT_DBG: begin
                dbg_req_ready = 1'b1;
                ram_addr      = dbg_req_addr;
                ram_we        = dbg_req_we;
                ram_wdata     = dbg_req_we ? dbg_req_wdata : '0;
                rdTagNext     = dbg_req_we ? TAG_NONE : TAG_DBG;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPtr       <= SCREEN_BASE;
            prefetchActive <= 1'b0;
            rdTag          <= TAG_NONE;
        end else begin
            if (vga_frame_start) begin
                fetchPtr       <= SCREEN_BASE;
                prefetchActive <= 1'b1;
            end else if (grant == GNT_VGA) begin
                fetchPtr <= fetchPtr + 1'b1;
                if (fetchPtr == LAST_ADDR) begin
                    prefetchActive <= 1'b0;
                end
            end
            rdTag <= rdTagNext;
        end
    end

    // Flush wins over a same-cycle push, so a read issued before a frame restart is dropped.
    dmem_prefetch_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) uFifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (vga_frame_start),
        .push     (vgaInflight),
        .pushData (ram_rdata),
        .pop      (vga_pop),
        .headData (vga_data),
        .empty    (vga_empty),
        .count    (fifoCount),
        .underrun (vga_underrun)
    );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural port-B RAM; memory preloaded
// with mem[a] = a*3 + 1111h so expected read data is known by hand.
module tb_dmem_port_arbiter;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_wr_en;
    logic [ADDR_W-1:0] cpu_wr_addr;
    logic [DATA_W-1:0] cpu_wr_data;
    logic              vga_frame_start;
    logic              vga_pop;
    logic [DATA_W-1:0] vga_data;
    logic              vga_empty;
    logic              vga_underrun;
    logic              dbg_req_valid;
    logic              dbg_req_ready;
    logic              dbg_req_we;
    logic [ADDR_W-1:0] dbg_req_addr;
    logic [DATA_W-1:0] dbg_req_wdata;
    logic              dbg_rsp_valid;
    logic [DATA_W-1:0] dbg_rsp_data;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_wr_en       (cpu_wr_en),
        .cpu_wr_addr     (cpu_wr_addr),
        .cpu_wr_data     (cpu_wr_data),
        .vga_frame_start (vga_frame_start),
        .vga_pop         (vga_pop),
        .vga_data        (vga_data),
        .vga_empty       (vga_empty),
        .vga_underrun    (vga_underrun),
        .dbg_req_valid   (dbg_req_valid),
        .dbg_req_ready   (dbg_req_ready),
        .dbg_req_we      (dbg_req_we),
        .dbg_req_addr    (dbg_req_addr),
        .dbg_req_wdata   (dbg_req_wdata),
        .dbg_rsp_valid   (dbg_rsp_valid),
        .dbg_rsp_data    (dbg_rsp_data),
        .ram_addr        (ram_addr),
        .ram_we          (ram_we),
        .ram_wdata       (ram_wdata),
        .ram_rdata       (ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [ADDR_W-1:0] fsAddr [8];
        logic [DATA_W-1:0] fsHead [4];
        logic [ADDR_W-1:0] lastAddr;
        logic [DATA_W-1:0] lastPop;
        int grants, popped, idleGrants;

        fsAddr = '{15'h4000, 15'h4001, 15'h4002, 15'h4003, 15'h0, 15'h0, 15'h0, 15'h0};
        fsHead = '{16'hD111, 16'hD114, 16'hD117, 16'hD11A};
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'(i * 3 + 32'h1111);

        rst = 1'b1; cpu_wr_en = 1'b0; cpu_wr_addr = '0; cpu_wr_data = '0;
        vga_frame_start = 1'b0; vga_pop = 1'b0;
        dbg_req_valid = 1'b0; dbg_req_we = 1'b0; dbg_req_addr = '0; dbg_req_wdata = '0;
        repeat (3) nextCycle();
        @(negedge clk);
        checkEq("rst_vga_empty", vga_empty, 1);
        checkEq("rst_vga_data", vga_data, 0);
        checkEq("rst_underrun", vga_underrun, 0);
        checkEq("rst_dbg_ready", dbg_req_ready, 0);
        checkEq("rst_rsp_valid", dbg_rsp_valid, 0);
        checkEq("rst_rsp_data", dbg_rsp_data, 0);
        checkEq("rst_ram_we", ram_we, 0);
        checkEq("rst_ram_addr", ram_addr, 0);
        checkEq("rst_ram_wdata", ram_wdata, 0);
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkEq("idle_before_frame", ram_addr, 0);
        nextCycle();

        // Frame start: four back-to-back reads, then stop with the FIFO full.
        vga_frame_start = 1'b1;
        @(negedge clk);
        checkEq("fs_cycle_no_grant", ram_addr, 0);
        nextCycle();
        vga_frame_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkEq($sformatf("fs_addr%0d", i), ram_addr, fsAddr[i]);
            if (i == 1) checkEq("fs_empty_n1", vga_empty, 1);
            if (i == 2) begin
                checkEq("fs_empty_n2", vga_empty, 0);
                checkEq("fs_data_n2", vga_data, 16'hD111);
            end
            nextCycle();
        end
        for (int j = 0; j < 4; j++) begin
            vga_pop = 1'b1;
            @(negedge clk);
            checkEq($sformatf("fs_head%0d", j), vga_data, fsHead[j]);
            nextCycle();
        end
        vga_pop = 1'b0;
        repeat (6) nextCycle();
        @(negedge clk);
        checkEq("full_idle_addr", ram_addr, 0);
        nextCycle();

        // CPU stores hold the port for 10 cycles; prefetch resumes at 4008h.
        for (int i = 0; i < 10; i++) begin
            cpu_wr_en = 1'b1;
            cpu_wr_addr = 15'(32'h0200 + i);
            cpu_wr_data = 16'(32'hBEE0 + i);
            vga_pop = (i == 0);
            @(negedge clk);
            checkEq($sformatf("cpu_we%0d", i), ram_we, 1);
            checkEq($sformatf("cpu_addr%0d", i), ram_addr, 32'h0200 + i);
            checkEq($sformatf("cpu_wdata%0d", i), ram_wdata, 32'hBEE0 + i);
            nextCycle();
        end
        cpu_wr_en = 1'b0; vga_pop = 1'b0;
        @(negedge clk);
        checkEq("cpu_resume_addr", ram_addr, 15'h4008);
        checkEq("cpu_resume_we", ram_we, 0);
        checkEq("cpu_store_mem", mem[15'h0205], 16'hBEE5);
        nextCycle();
        repeat (6) nextCycle();

        vga_frame_start = 1'b1;
        nextCycle();
        vga_frame_start = 1'b0;
`ifdef DMEM_ARB_DEBUG_EN
        dbg_req_valid = 1'b1; dbg_req_we = 1'b0; dbg_req_addr = 15'h0123;
        @(negedge clk);
        checkEq("dbg_rd_ready", dbg_req_ready, 1);
        checkEq("dbg_rd_addr", ram_addr, 15'h0123);
        checkEq("dbg_rd_we", ram_we, 0);
        nextCycle();
        dbg_req_we = 1'b1; dbg_req_addr = 15'h0300; dbg_req_wdata = 16'h1234;
        @(negedge clk);
        checkEq("rr_vga_ready", dbg_req_ready, 0);
        checkEq("rr_vga_addr", ram_addr, 15'h4000);
        checkEq("rsp_not_yet", dbg_rsp_valid, 0);
        nextCycle();
        @(negedge clk);
        checkEq("dbg_wr_ready", dbg_req_ready, 1);
        checkEq("dbg_wr_addr", ram_addr, 15'h0300);
        checkEq("dbg_wr_we", ram_we, 1);
        checkEq("dbg_wr_wdata", ram_wdata, 16'h1234);
        checkEq("rsp_valid", dbg_rsp_valid, 1);
        checkEq("rsp_data", dbg_rsp_data, 16'h147A);
        nextCycle();
        dbg_req_valid = 1'b0;
        @(negedge clk);
        checkEq("rr_vga_addr2", ram_addr, 15'h4001);
        checkEq("rsp_one_pulse", dbg_rsp_valid, 0);
        nextCycle();
        @(negedge clk);
        checkEq("wr_no_rsp", dbg_rsp_valid, 0);
        nextCycle();
`else
        dbg_req_valid = 1'b1; dbg_req_we = 1'b1; dbg_req_addr = 15'h0300;
        dbg_req_wdata = 16'h1234;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkEq($sformatf("nodbg_ready%0d", i), dbg_req_ready, 0);
            checkEq($sformatf("nodbg_addr%0d", i), ram_addr, fsAddr[i]);
            checkEq($sformatf("nodbg_we%0d", i), ram_we, 0);
            checkEq($sformatf("nodbg_rsp%0d", i), dbg_rsp_valid, 0);
            nextCycle();
        end
        dbg_req_valid = 1'b0;
`endif
        repeat (8) nextCycle();

        // Restart with a read in flight and three words buffered.
        vga_pop = 1'b1;
        nextCycle();
        vga_pop = 1'b0;
        @(negedge clk);
        checkEq("preflush_issue", ram_addr, 15'h4004);
        nextCycle();
        vga_frame_start = 1'b1;
        @(negedge clk);
        checkEq("preflush_nonempty", vga_empty, 0);
        nextCycle();
        vga_frame_start = 1'b0;
        vga_pop = 1'b1;
        @(negedge clk);
        checkEq("flush_empty", vga_empty, 1);
        checkEq("underrun_pulse", vga_underrun, 1);
        checkEq("flush_reissue", ram_addr, 15'h4000);
        nextCycle();
        vga_pop = 1'b0;
        @(negedge clk);
        checkEq("underrun_cleared", vga_underrun, 0);
        checkEq("underrun_still_empty", vga_empty, 1);
        checkEq("flush_issue2", ram_addr, 15'h4001);
        nextCycle();
        @(negedge clk);
        checkEq("no_stale_empty", vga_empty, 0);
        checkEq("no_stale_data", vga_data, 16'hD111);
        nextCycle();

        // Full frame with continuous consumption.
        vga_frame_start = 1'b1;
        nextCycle();
        vga_frame_start = 1'b0;
        grants = 0; popped = 0; lastAddr = '0; lastPop = '0;
        for (int c = 0; c < 40000 && popped < 8192; c++) begin
            vga_pop = !vga_empty;
            @(negedge clk);
            if (ram_addr != 0 && !ram_we) begin
                grants++;
                lastAddr = ram_addr;
            end
            if (vga_pop) begin
                popped++;
                lastPop = vga_data;
            end
            nextCycle();
        end
        vga_pop = 1'b0;
        checkEq("frame_popped", popped, 8192);
        checkEq("frame_grants", grants, 8192);
        checkEq("frame_last_addr", lastAddr, 15'h5FFF);
        checkEq("frame_last_word", lastPop, 16'h310E);
        idleGrants = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ram_addr != 0) idleGrants++;
            nextCycle();
        end
        checkEq("frame_idle_after", idleGrants, 0);
        checkEq("frame_drained", vga_empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
